imm_gen_stage: RTL and testbench

Registered, handshaked immediate-generation stage for the decode pipeline. It extracts and sign- or zero-extends the immediate from a 25-bit instruction body (opcode stripped) to XLEN bits, and covers I/B/S/U/J plus shift-amount and CSR-zimm formats. A 2-entry skid buffer decouples upstream fetch/decode from the execute stage and carries a sideband tag alongside each immediate. Illegal format codes are flagged per item and can optionally be counted.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_extract.sv | 52 +++++
 rtl/imm_gen_stage.sv | 132 +++++++++++++
 tb/tb_imm_gen_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate-generation stage.
//   - format codes driven on in_imm_type
//   - legal XLEN values and a check helper
//   - storage entry for the skid buffer, sized for the widest supported
//     configuration; narrower builds use the low bits only
package imm_pkg;

    localparam logic [2:0] IMM_I       = 3'd0;
    localparam logic [2:0] IMM_B       = 3'd1;
    localparam logic [2:0] IMM_S       = 3'd2;
    localparam logic [2:0] IMM_U       = 3'd3;
    localparam logic [2:0] IMM_J       = 3'd4;
    localparam logic [2:0] IMM_SH      = 3'd5;
    localparam logic [2:0] IMM_Z       = 3'd6;
    localparam logic [2:0] IMM_ILLEGAL = 3'd7;

    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;

    localparam int unsigned IMM_MAX_W = XLEN_64;
    localparam int unsigned TAG_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 illegal;
    } imm_entry_t;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction and extension.
// Ports:
//   instr     in   instruction bits [31:7], indexed by instruction bit number
//   imm_type  in   format code (see imm_pkg)
//   imm       out  XLEN-wide extended immediate (all-ones for an illegal code)
//   illegal   out  format code was illegal
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Every format is first built as a 32-bit value. Zero-extended formats
    // (SH, Z) have bit 31 clear and the illegal pattern is all-ones, so a
    // plain sign extension from bit 31 gives the right XLEN=64 result for all.
    logic [31:0] imm32;

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        unique case (imm_type)
            IMM_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
            IMM_U:  imm32 = {instr[31:12], 12'b0};
            IMM_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            IMM_SH: begin
                if (XLEN == XLEN_64) imm32 = {26'b0, instr[25:20]};
                else                 imm32 = {27'b0, instr[24:20]};
            end
            IMM_Z:  imm32 = {27'b0, instr[19:15]};
            default: begin
                imm32   = '1;
                illegal = 1'b1;
            end
        endcase
    end

    if (XLEN == XLEN_64) begin : g_xlen64
        assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_xlen32
        assign imm = imm32;
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered, handshaked immediate-generation stage.
// The immediate is extracted when an item is accepted and stored with its
// tag and illegal flag in a 2-entry FIFO; the head entry drives out_*.
// in_ready depends only on registered occupancy.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous flush: empties the buffer, drops this cycle's accept/pop
//   in_valid/in_ready, in_instr[31:7], in_imm_type, in_tag   upstream side
//   out_valid/out_ready, out_imm, out_tag, out_illegal       downstream side
//   illegal_count   saturating count of accepted illegal-code items
// Build option: define IMM_ILLEGAL_CNT_EN to build the illegal counter;
// otherwise illegal_count is tied to zero.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:7]      in_instr,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end
    if (TAG_W > TAG_MAX_W) begin : g_bad_tag
        $error("imm_gen_stage: TAG_W too wide");
    end

    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .instr    (in_instr),
        .imm_type (in_imm_type),
        .imm      (ext_imm),
        .illegal  (ext_illegal)
    );

    imm_entry_t mem_q [2];
    imm_entry_t new_entry;
    imm_entry_t head;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        new_entry                  = '0;
        new_entry.imm[XLEN-1:0]    = ext_imm;
        new_entry.tag[TAG_W-1:0]   = in_tag;
        new_entry.illegal          = ext_illegal;
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= new_entry;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_tag     = head.tag[TAG_W-1:0];
    assign out_illegal = head.illegal;

    // Upper entry bits beyond XLEN/TAG_W are constant zero in narrow builds.
    logic unused_hi;
    assign unused_hi = ^{head.imm >> XLEN, head.tag >> TAG_W};

`ifdef IMM_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count_q <= '0;
        end else if (push && ext_illegal && (illegal_count_q != {CNT_W{1'b1}})) begin
            illegal_count_q <= illegal_count_q + 1'b1;
        end
    end

    assign illegal_count = illegal_count_q;
`else
    assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed bench for imm_gen_stage. Two instances (XLEN=32
// and XLEN=64) share the same stimulus.
module tb_imm_gen_stage;
    import imm_pkg::*;

    localparam int unsigned TAG_W = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      instr_full;
    logic [2:0]       in_imm_type;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready_32, out_valid_32, out_illegal_32;
    logic [31:0]      out_imm_32;
    logic [TAG_W-1:0] out_tag_32;
    logic [CNT_W-1:0] cnt_32;

    logic             in_ready_64, out_valid_64, out_illegal_64;
    logic [63:0]      out_imm_64;
    logic [TAG_W-1:0] out_tag_64;
    logic [CNT_W-1:0] cnt_64;

    int errors = 0;
    int checks = 0;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut32 (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready_32),
        .in_instr      (instr_full[31:7]),
        .in_imm_type   (in_imm_type),
        .in_tag        (in_tag),
        .out_valid     (out_valid_32),
        .out_ready     (out_ready),
        .out_imm       (out_imm_32),
        .out_tag       (out_tag_32),
        .out_illegal   (out_illegal_32),
        .illegal_count (cnt_32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut64 (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready_64),
        .in_instr      (instr_full[31:7]),
        .in_imm_type   (in_imm_type),
        .in_tag        (in_tag),
        .out_valid     (out_valid_64),
        .out_ready     (out_ready),
        .out_imm       (out_imm_64),
        .out_tag       (out_tag_64),
        .out_illegal   (out_illegal_64),
        .illegal_count (cnt_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one item with out_ready=1, check it one cycle later, then let it drain.
    task automatic run_vec(input string name, input logic [31:0] ins, input logic [2:0] t,
                           input logic [31:0] exp32, input logic [63:0] exp64);
        instr_full  = ins;
        in_imm_type = t;
        in_tag      = ins ^ 32'h5A5A_0000;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        check({name, "_valid"},   {63'b0, out_valid_32},   64'd1);
        check({name, "_imm32"},   {32'b0, out_imm_32},     {32'b0, exp32});
        check({name, "_imm64"},   out_imm_64,              exp64);
        check({name, "_tag"},     {32'b0, out_tag_32},     {32'b0, ins ^ 32'h5A5A_0000});
        check({name, "_illegal"}, {63'b0, out_illegal_32}, 64'd0);
        tick();
        check({name, "_drained"}, {63'b0, out_valid_32},   64'd0);
    endtask

    logic [CNT_W-1:0] exp_cnt;

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        instr_full  = '0;
        in_imm_type = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        #1;
        check("rst_in_ready",  {63'b0, in_ready_32},    64'd1);
        check("rst_out_valid", {63'b0, out_valid_32},   64'd0);
        check("rst_out_imm",   out_imm_64,              64'd0);
        check("rst_out_tag",   {32'b0, out_tag_32},     64'd0);
        check("rst_illegal",   {63'b0, out_illegal_32}, 64'd0);
        check("rst_count",     {56'b0, cnt_32},         64'd0);
        #12;
        rst_n = 1'b1;
        tick();

        run_vec("i_addi", 32'hFFF0_0093, IMM_I,  32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_vec("u_lui",  32'h8000_00B7, IMM_U,  32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        run_vec("sh",     32'h03F0_9093, IMM_SH, 32'd31,        64'd63);
        run_vec("b",      32'hFE00_0EE3, IMM_B,  32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
        run_vec("j",      32'h0010_006F, IMM_J,  32'h0000_0800, 64'h0000_0000_0000_0800);
        run_vec("s_sw",   32'hFE11_2E23, IMM_S,  32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
        run_vec("z_csr",  32'h000F_8073, IMM_Z,  32'd31,        64'd31);

        // Backpressure: tags 1,2,3 offered back-to-back with out_ready low.
        instr_full  = 32'hFFF0_0093;
        in_imm_type = IMM_I;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_tag      = 32'd1;
        tick();
        check("bp_ready_after1", {63'b0, in_ready_32}, 64'd1);
        in_tag = 32'd2;
        tick();
        check("bp_ready_after2", {63'b0, in_ready_32}, 64'd0);
        in_tag = 32'd3;
        tick();
        check("bp_held_ready",   {63'b0, in_ready_32}, 64'd0);
        check("bp_head1",        {32'b0, out_tag_32},  64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_head2",        {32'b0, out_tag_32},  64'd2);
        check("bp_ready_again",  {63'b0, in_ready_32}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_head3",        {32'b0, out_tag_32},  64'd3);
        check("bp_valid3",       {63'b0, out_valid_32}, 64'd1);
        tick();
        check("bp_empty",        {63'b0, out_valid_32}, 64'd0);

        // Illegal code three times; the third accept is flushed.
        in_imm_type = IMM_ILLEGAL;
        in_tag      = 32'hA0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        check("ill1_imm32",   {32'b0, out_imm_32},     64'h0000_0000_FFFF_FFFF);
        check("ill1_imm64",   out_imm_64,              64'hFFFF_FFFF_FFFF_FFFF);
        check("ill1_flag",    {63'b0, out_illegal_32}, 64'd1);
        in_tag = 32'hA1;
        tick();
        in_valid = 1'b0;
        check("ill2_imm32",   {32'b0, out_imm_32},     64'h0000_0000_FFFF_FFFF);
        check("ill2_flag",    {63'b0, out_illegal_32}, 64'd1);
        check("ill2_tag",     {32'b0, out_tag_32},     64'hA1);
        tick();
        in_valid = 1'b1;
        flush    = 1'b1;
        in_tag   = 32'hA2;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
`ifdef IMM_ILLEGAL_CNT_EN
        exp_cnt = 8'd2;
`else
        exp_cnt = 8'd0;
`endif
        check("ill_flushed_valid", {63'b0, out_valid_32}, 64'd0);
        check("ill_count32",       {56'b0, cnt_32},       {56'b0, exp_cnt});
        check("ill_count64",       {56'b0, cnt_64},       {56'b0, exp_cnt});

        // Fill to two entries, then assert reset mid-cycle.
        in_imm_type = IMM_I;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_tag      = 32'h55;
        tick();
        in_tag = 32'h66;
        tick();
        in_valid = 1'b0;
        check("full_ready", {63'b0, in_ready_32}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'b0, out_valid_32}, 64'd0);
        check("arst_in_ready",  {63'b0, in_ready_32},  64'd1);
        check("arst_count",     {56'b0, cnt_32},       64'd0);
        check("arst_out_imm",   {32'b0, out_imm_32},   64'd0);
        check("arst_out_tag",   {32'b0, out_tag_32},   64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {63'b0, out_valid_64}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
